// File: rtl/sram_pkg.sv
// sram_pkg: shared definitions for the sram_bank slice.
//   RDW_OLD / RDW_NEW : read-during-write mode selectors
//   state_e           : bank FSM states (ST_CLEAR sweep, ST_READY service)
//   calc_nb()         : byte-lane count, 0 when the widths are not legal
package sram_pkg;

  localparam int unsigned RDW_OLD = 0;
  localparam int unsigned RDW_NEW = 1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // Returns DATA_WIDTH/BYTE_WIDTH, or 0 if the word is not a whole number of lanes.
  function automatic int unsigned calc_nb(input int unsigned dw, input int unsigned bw);
    if (bw == 0 || dw == 0 || (dw % bw) != 0) begin
      return 0;
    end
    return dw / bw;
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// sram_rd_pipe: STAGES-deep valid/data delay line for read responses.
//   clk, rst : clock, synchronous active-high reset (clears valids and data)
//   i_valid  : response valid entering the line
//   i_data   : response data entering the line
//   o_valid  : delayed valid
//   o_data   : delayed data; each stage loads only when its input is valid,
//              so the output holds between responses
module sram_rd_pipe #(
  parameter int unsigned STAGES = 1,
  parameter int unsigned WIDTH  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_v [STAGES];
  logic [WIDTH-1:0] r_d [STAGES];

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic             w_in_v;
    logic [WIDTH-1:0] w_in_d;

    if (g == 0) begin : g_first
      assign w_in_v = i_valid;
      assign w_in_d = i_data;
    end else begin : g_next
      assign w_in_v = r_v[g-1];
      assign w_in_d = r_d[g-1];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_v[g] <= 1'b0;
        r_d[g] <= '0;
      end else begin
        r_v[g] <= w_in_v;
        if (w_in_v) begin
          r_d[g] <= w_in_d;
        end
      end
    end
  end

  assign o_valid = r_v[STAGES-1];
  assign o_data  = r_d[STAGES-1];

endmodule

// File: rtl/sram_bank.sv
// sram_bank: single-port synchronous SRAM bank with valid/ready request port.
//   clk, rst   : clock, synchronous active-high reset
//   req_valid  : request present;  req_ready : bank accepts (registered)
//   req_we/re  : write / read this request (both allowed, same address)
//   req_be     : byte-lane write enables, qualified by req_we
//   req_addr   : word address;  req_wdata : write data
//   rsp_valid  : one-cycle pulse, rsp_rdata holds the read word
//   rsp_rdata  : read data, held between responses
//   busy       : zero-fill sweep in progress (registered)
module sram_bank
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned BYTE_WIDTH     = 8,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned RDW_MODE       = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_we,
  input  logic                             req_re,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] req_be,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic [DATA_WIDTH-1:0]            req_wdata,
  output logic                             rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             busy
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned NB    = calc_nb(DATA_WIDTH, BYTE_WIDTH);

  if (NB == 0 || READ_LATENCY < 1 || READ_LATENCY > 3) begin : g_param_check
    $error("sram_bank: illegal DATA_WIDTH/BYTE_WIDTH or READ_LATENCY");
  end

  state_e                  r_state;
  logic [ADDR_WIDTH-1:0]   r_clr_addr;
  logic                    r_ready;
  logic                    r_busy;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
  logic                    r_s1_valid;
  logic [DATA_WIDTH-1:0]   r_s1_data;

  logic                    w_accept;
  logic                    w_rd;
  logic                    w_wr;
  logic [DATA_WIDTH-1:0]   w_wmask;
  logic [DATA_WIDTH-1:0]   w_old;
  logic [DATA_WIDTH-1:0]   w_merged;
  logic [DATA_WIDTH-1:0]   w_rd_word;

  assign req_ready = r_ready;
  assign busy      = r_busy;

  assign w_accept = req_valid && r_ready;
  assign w_rd     = w_accept && req_re;
  assign w_wr     = w_accept && req_we && (|req_be);

  // Bit mask of the lanes this request writes; zero when req_we is low.
  for (genvar g = 0; g < NB; g++) begin : g_mask
    assign w_wmask[g*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{req_we & req_be[g]}};
  end

  // One read port serves both the response and the lane merge for writes,
  // so the RDW_NEW response and the stored word are the same value.
  assign w_old     = r_mem[req_addr];
  assign w_merged  = (w_old & ~w_wmask) | (req_wdata & w_wmask);
  assign w_rd_word = (RDW_MODE == RDW_NEW) ? w_merged : w_old;

  // Clear FSM with registered ready/busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      r_clr_addr <= '0;
      r_busy     <= (CLEAR_ON_RESET != 0);
      r_ready    <= (CLEAR_ON_RESET == 0);
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_clr_addr <= r_clr_addr + 1'b1;
          if (r_clr_addr == '1) begin
            r_state <= ST_READY;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  // Array: no reset so contents survive rst when the sweep is disabled.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == ST_CLEAR) begin
        r_mem[r_clr_addr] <= '0;
      end else if (w_wr) begin
        r_mem[req_addr] <= w_merged;
      end
    end
  end

  // First response stage samples the array at acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
    end else begin
      r_s1_valid <= w_rd;
      if (w_rd) begin
        r_s1_data <= w_rd_word;
      end
    end
  end

  if (READ_LATENCY > 1) begin : g_pipe
    sram_rd_pipe #(
      .STAGES(READ_LATENCY - 1),
      .WIDTH (DATA_WIDTH)
    ) u_rd_pipe (
      .clk    (clk),
      .rst    (rst),
      .i_valid(r_s1_valid),
      .i_data (r_s1_data),
      .o_valid(rsp_valid),
      .o_data (rsp_rdata)
    );
  end else begin : g_no_pipe
    assign rsp_valid = r_s1_valid;
    assign rsp_rdata = r_s1_data;
  end

endmodule
